// File: rtl/axi_read_master_if.sv
// AXI4 bus bundle for the read initiator. AR and R carry the traffic;
// AW/W/B keep only their handshake wires so the master can hold them idle.
interface axi_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic              awvalid;
  logic              awready;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport m (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awvalid, wvalid, bready,
    input  awready, wready, bvalid
  );

  modport s (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awvalid, wvalid, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/axi_read_master.sv
// AXI4 read initiator: one burst in flight, R beats buffered in a small FIFO
// and streamed to the core on a ready/valid port.
// Optional: define AXI_RD_ID_CHECK_EN to drop and flag beats whose RID does
// not match the issued ARID.
module axi_read_master #(
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_R_WIDTH-1:0] cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  err,
  axi_if.m                      axi_m
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ID_R_WIDTH-1:0] arid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  logic [1:0]            arburst_q;
  logic [7:0]            beat_cnt_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [1:0]            mem_resp_q [FIFO_DEPTH];
  logic                  mem_last_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q, count_d;

  logic arvalid, rready, fifo_full, r_hs, id_ok, push, pop, cnt_zero, err_set;

  // FIFO occupancy and channel handshakes; RREADY looks only at the
  // registered count so a same-cycle pop never opens the R channel.
  always_comb begin
    fifo_full = (count_q == CW'(FIFO_DEPTH));
    rready    = (state_q == S_DATA) && !fifo_full;
    r_hs      = axi_m.rvalid && rready;
`ifdef AXI_RD_ID_CHECK_EN
    id_ok     = (axi_m.rid == arid_q);
`else
    id_ok     = 1'b1;
`endif
    push      = r_hs && id_ok;
    rd_valid  = (count_q != '0);
    pop       = rd_valid && rd_ready;
    count_d   = count_q + CW'(push) - CW'(pop);
    cnt_zero  = (beat_cnt_q == 8'd0);
    // Response error, stray RLAST, missing RLAST, or (optionally) foreign RID.
    err_set   = r_hs && ((axi_m.rresp != 2'b00) || !id_ok ||
                         (axi_m.rlast != cnt_zero));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and FSM outputs. DRAIN leaves on the edge that empties the
  // FIFO, so busy drops right as the last beat is consumed.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    arvalid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_ADDR;
      end
      S_ADDR: begin
        arvalid = 1'b1;
        if (axi_m.arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (push && cnt_zero) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (count_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, beat counter, FIFO pointers and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arid_q     <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      beat_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        arid_q    <= cmd_id;
        araddr_q  <= cmd_addr;
        arlen_q   <= cmd_len;
        arsize_q  <= cmd_size;
        arburst_q <= cmd_burst;
      end
      if (arvalid && axi_m.arready) beat_cnt_q <= arlen_q;
      else if (push && !cnt_zero)   beat_cnt_q <= beat_cnt_q - 8'd1;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  // FIFO storage; the last flag comes from the beat counter, not RLAST.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wptr_q] <= axi_m.rdata;
      mem_resp_q[wptr_q] <= axi_m.rresp;
      mem_last_q[wptr_q] <= cnt_zero;
    end
  end

  assign rd_data = rd_valid ? mem_data_q[rptr_q] : '0;
  assign rd_resp = rd_valid ? mem_resp_q[rptr_q] : 2'b00;
  assign rd_last = rd_valid ? mem_last_q[rptr_q] : 1'b0;
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;

  assign axi_m.arid    = arid_q;
  assign axi_m.araddr  = araddr_q;
  assign axi_m.arlen   = arlen_q;
  assign axi_m.arsize  = arsize_q;
  assign axi_m.arburst = arburst_q;
  assign axi_m.arvalid = arvalid;
  assign axi_m.rready  = rready;

  // Write side never issues anything.
  assign axi_m.awvalid = 1'b0;
  assign axi_m.wvalid  = 1'b0;
  assign axi_m.bready  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{axi_m.awready, axi_m.wready, axi_m.bvalid, axi_m.rid};

endmodule

// File: tb/tb_axi_read_master.sv
// Randomized bench for axi_read_master: a scripted AXI slave, a random-ready
// consumer, and a queue-based model of which beats must come out and when
// err must be set.
module tb_axi_read_master;
  localparam int IDW = 4, AW = 16, DW = 32, FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [IDW-1:0] cmd_id;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic          rd_valid, rd_ready, rd_last, busy, err;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;

  axi_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) axi ();

  axi_read_master #(.ID_R_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_resp(rd_resp), .rd_last(rd_last), .busy(busy), .err(err), .axi_m(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  d;
    logic [1:0]     r;
    logic           l;
    logic [IDW-1:0] id;
  } beat_t;

  beat_t sq[$];   // what the slave will send
  beat_t eq[$];   // what the core must receive
  int    checks = 0, failures = 0;
  int    hs_cnt;
  bit    exp_err = 1'b0;
  logic [IDW-1:0] cur_id;
  logic [AW-1:0]  cur_addr;
  logic [7:0]     cur_len;
  logic [2:0]     cur_size;
  logic [1:0]     cur_burst;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: beats counted in order; the beat whose index equals len is
  // the last one; anything after the counter ends isn't sent by the script.
  function automatic void build_expect();
    int k = 0;
    eq.delete();
    foreach (sq[i]) begin
      beat_t b = sq[i];
      bit last;
      if (b.r != 2'b00) exp_err = 1'b1;
`ifdef AXI_RD_ID_CHECK_EN
      if (b.id != cur_id) begin exp_err = 1'b1; continue; end
`endif
      last = (k == int'(cur_len));
      if (b.l != last) exp_err = 1'b1;
      eq.push_back('{d: b.d, r: b.r, l: last, id: b.id});
      k++;
    end
  endfunction

  task automatic make_script();
    sq.delete();
    for (int i = 0; i <= int'(cur_len); i++)
      sq.push_back('{d: $urandom, r: 2'b00, l: (i == int'(cur_len)), id: cur_id});
  endtask

  task automatic issue_cmd();
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_id = cur_id; cmd_addr = cur_addr;
    cmd_len = cur_len; cmd_size = cur_size; cmd_burst = cur_burst;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("arvalid_lat1", axi.arvalid, 1);
    chk("arid", axi.arid, cur_id);
    chk("araddr", axi.araddr, cur_addr);
    chk("arlen", axi.arlen, cur_len);
    chk("arsize", axi.arsize, cur_size);
    chk("arburst", axi.arburst, cur_burst);
    chk("busy_on", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic slave_ar(input int dly);
    for (int i = 0; i < dly; i++) begin
      chk("ar_hold_valid", axi.arvalid, 1);
      chk("ar_hold_addr", axi.araddr, cur_addr);
      chk("ar_hold_cmdrdy", cmd_ready, 0);
      @(negedge clk);
    end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    chk("ar_drop", axi.arvalid, 0);
  endtask

  // Sends the script; with stop_after>=0 returns presenting beat stop_after.
  task automatic slave_r(input int stop_after, input bit gaps);
    foreach (sq[i]) begin
      int w = 0;
      if (gaps && $urandom_range(3) == 0) begin axi.rvalid = 1'b0; @(negedge clk); end
      axi.rvalid = 1'b1; axi.rdata = sq[i].d; axi.rresp = sq[i].r;
      axi.rlast = sq[i].l; axi.rid = sq[i].id;
      if (stop_after >= 0 && hs_cnt == stop_after) return;
      while (!axi.rready && w < 400) begin @(negedge clk); w++; end
      if (!axi.rready) begin chk("rready_timeout", 0, 1); axi.rvalid = 1'b0; return; end
      @(negedge clk);
      hs_cnt++;
    end
    axi.rvalid = 1'b0;
  endtask

  task automatic consume(input int pct);
    int cyc = 0;
    while (eq.size() > 0 && cyc < 3000) begin
      rd_ready = ($urandom_range(99) < pct);
      if (rd_valid && rd_ready) begin
        beat_t e = eq.pop_front();
        chk("rd_data", rd_data, e.d);
        chk("rd_resp", rd_resp, e.r);
        chk("rd_last", rd_last, e.l);
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    if (eq.size() > 0) chk("consume_timeout", eq.size(), 0);
    chk("busy_off", busy, 0);
    chk("rd_valid_off", rd_valid, 0);
  endtask

  task automatic run_burst(input int dly, input int pct, input bit gaps);
    build_expect();
    issue_cmd();
    hs_cnt = 0;
    fork
      begin slave_ar(dly); slave_r(-1, gaps); end
      consume(pct);
    join
    chk("err", err, exp_err);
  endtask

  task automatic check_reset_vals();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_resp", rd_resp, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_bready", axi.bready, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; cmd_burst = '0; rd_ready = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    axi.rlast = 1'b0; axi.rid = '0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // single beat
    cur_id = 4'd1; cur_addr = 16'h0004; cur_len = 8'd0; cur_size = 3'd2; cur_burst = 2'd1;
    make_script();
    sq[0].d = 32'hFFFF0000;
    run_burst(0, 100, 1'b0);

    // 8-beat INCR, consumer held off until the FIFO fills
    cur_id = 4'd2; cur_addr = 16'h0100; cur_len = 8'd7;
    make_script();
    build_expect();
    issue_cmd();
    hs_cnt = 0;
    fork
      begin slave_ar(0); slave_r(-1, 1'b0); end
      begin
        int w = 0;
        while (hs_cnt < FD && w < 200) begin @(negedge clk); w++; end
        repeat (2) @(negedge clk);
        chk("full_hs_cnt", hs_cnt, FD);
        chk("rready_full", axi.rready, 0);
        chk("full_rd_valid", rd_valid, 1);
        consume(60);
      end
    join
    chk("err", err, exp_err);

    // ARREADY held off 5 cycles
    cur_id = 4'd4; cur_addr = 16'hBEE0; cur_len = 8'd1;
    make_script();
    run_burst(5, 80, 1'b0);

    // len=3, early RLAST on beat 2, SLVERR on beat 3
    cur_id = 4'd6; cur_addr = 16'h0200; cur_len = 8'd3;
    make_script();
    sq[1].l = 1'b1;
    sq[2].r = 2'b10;
    run_burst(1, 70, 1'b0);
    chk("err_set", err, 1);

    // reset during beat 2 of a len=7 burst
    cur_id = 4'd7; cur_addr = 16'h0300; cur_len = 8'd7;
    make_script();
    issue_cmd();
    hs_cnt = 0;
    slave_ar(0);
    slave_r(1, 1'b0);
    chk("r_to_rd_valid_lat1", rd_valid, 1);
    chk("rd_data_first", rd_data, sq[0].d);
    #1 rst = 1'b1;
    #1 check_reset_vals();
    exp_err = 1'b0;
    axi.rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // normal command after reset
    cur_id = 4'd9; cur_addr = 16'h0400; cur_len = 8'd5;
    make_script();
    run_burst(2, 50, 1'b1);

    // randomized bursts with occasional protocol errors
    for (int t = 0; t < 8; t++) begin
      cur_id = 4'($urandom); cur_addr = 16'($urandom); cur_len = 8'($urandom_range(20));
      cur_size = 3'($urandom_range(2)); cur_burst = 2'($urandom_range(2));
      make_script();
      foreach (sq[i]) begin
        if ($urandom_range(19) == 0) sq[i].r = 2'($urandom_range(1, 3));
        if ($urandom_range(29) == 0) sq[i].l = ~sq[i].l;
      end
      run_burst($urandom_range(4), $urandom_range(20, 100), 1'b1);
    end

    // full-length burst
    cur_id = 4'd3; cur_addr = 16'h8000; cur_len = 8'd255; cur_size = 3'd2; cur_burst = 2'd1;
    make_script();
    run_burst(0, 90, 1'b0);

`ifdef AXI_RD_ID_CHECK_EN
    // foreign RID beat dropped
    cur_id = 4'd3; cur_addr = 16'h0040; cur_len = 8'd3;
    make_script();
    sq.insert(2, '{d: 32'hDEADBEEF, r: 2'b00, l: 1'b0, id: 4'd5});
    run_burst(0, 80, 1'b0);
    chk("id_err", err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
